// File: rtl/board_mem_arbiter.sv
// rtl/board_mem_arbiter.sv - board RAM arbiter for VGA reads, player/AI read-modify-write and board clear
// Shares the single-port cell-status RAM. The VGA beam owns the RAM while enable
// is high. In blanking, the RAM serves a pending clear first, then player/AI
// requests in round-robin order. An operation that enable interrupts restarts
// from RD, so the read-modify-write never splits across a VGA window.
module board_mem_arbiter #(
  parameter int STATUS_W = 3,
  parameter int GRID_W   = 3
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [GRID_W-1:0]     vga_cell_x,
  input  logic [GRID_W-1:0]     vga_cell_y,
  output logic [STATUS_W-1:0]   vga_status,
  input  logic                  p_req,
  input  logic                  a_req,
  input  logic                  p_wr,
  input  logic                  a_wr,
  input  logic [GRID_W-1:0]     p_cell_x,
  input  logic [GRID_W-1:0]     p_cell_y,
  input  logic [GRID_W-1:0]     a_cell_x,
  input  logic [GRID_W-1:0]     a_cell_y,
  input  logic [STATUS_W-1:0]   p_mask,
  input  logic [STATUS_W-1:0]   a_mask,
  output logic                  p_ack,
  output logic                  a_ack,
  output logic [STATUS_W-1:0]   p_rdata,
  output logic [STATUS_W-1:0]   a_rdata,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic [2*GRID_W-1:0]   mem_addr,
  output logic                  mem_we,
  output logic [STATUS_W-1:0]   mem_wdata,
  input  logic [STATUS_W-1:0]   mem_rdata
);

  localparam int AW = 2 * GRID_W;

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, CLR} state_t;

  state_t              state, state_nx;
  logic [AW-1:0]       clr_cnt;
  logic [AW-1:0]       tgt_addr;
  logic                tgt_wr;
  logic [STATUS_W-1:0] tgt_mask;
  logic [STATUS_W-1:0] hold;
  logic [STATUS_W-1:0] vga_hold;
  logic                owner_ai;
  logic                rr_last_ai;
  logic                en_q;
  logic                grant;
  logic                pick_ai;
  logic                clr_last;
  logic                op_done;
  logic [STATUS_W-1:0] op_data;

  // RAM data for the previous VGA cycle passes straight through; between windows the last value is held
  assign vga_status = en_q ? mem_rdata : vga_hold;

  // Next state, RAM port drive and completion pulses; enable overrides every game-side access
  always_comb begin
    state_nx  = state;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    grant     = 1'b0;
    op_done   = 1'b0;
    op_data   = '0;
    pick_ai   = a_req & (~p_req | ~rr_last_ai);
    clr_last  = (clr_cnt == {AW{1'b1}});
    if (reset) begin
      state_nx = IDLE;
    end else if (enable) begin
      mem_addr = {vga_cell_y, vga_cell_x};
      if (state != IDLE && state != CLR) state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (clr_busy || clr_req) begin
            state_nx = CLR;
          end else if (p_req || a_req) begin
            grant    = 1'b1;
            state_nx = RD;
          end
        end
        RD: begin
          mem_addr = tgt_addr;
          state_nx = CAP;
        end
        CAP: begin
          mem_addr = tgt_addr;
          if (tgt_wr) begin
            state_nx = WR;
          end else begin
            op_done  = 1'b1;
            op_data  = mem_rdata;
            state_nx = IDLE;
          end
        end
        WR: begin
          mem_addr  = tgt_addr;
          mem_we    = 1'b1;
          mem_wdata = hold | tgt_mask;
          op_done   = 1'b1;
          op_data   = hold;
          state_nx  = IDLE;
        end
        CLR: begin
          mem_addr  = clr_cnt;
          mem_we    = 1'b1;
          mem_wdata = '0;
          if (clr_last) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
    p_ack   = op_done & ~owner_ai;
    a_ack   = op_done & owner_ai;
    p_rdata = (op_done & ~owner_ai) ? op_data : '0;
    a_rdata = (op_done & owner_ai) ? op_data : '0;
  end

  // State register, latched request, round-robin history and clear sequencing
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      tgt_addr   <= '0;
      tgt_wr     <= 1'b0;
      tgt_mask   <= '0;
      hold       <= '0;
      vga_hold   <= '0;
      owner_ai   <= 1'b0;
      rr_last_ai <= 1'b1;
      en_q       <= 1'b0;
      clr_busy   <= 1'b0;
      clr_done   <= 1'b0;
    end else begin
      state    <= state_nx;
      en_q     <= enable;
      clr_done <= 1'b0;
      if (en_q) vga_hold <= mem_rdata;
      if (clr_req) clr_busy <= 1'b1;
      if (grant) begin
        owner_ai <= pick_ai;
        tgt_addr <= pick_ai ? {a_cell_y, a_cell_x} : {p_cell_y, p_cell_x};
        tgt_wr   <= pick_ai ? a_wr : p_wr;
        tgt_mask <= pick_ai ? a_mask : p_mask;
      end
      if (state == CAP && !enable) hold <= mem_rdata;
      if (op_done) rr_last_ai <= owner_ai;
      if (state == CLR && !enable) begin
        if (clr_last) begin
          clr_busy <= 1'b0;
          clr_done <= 1'b1;
          clr_cnt  <= '0;
        end else begin
          clr_cnt <= clr_cnt + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_board_mem_arbiter.sv
// tb/tb_board_mem_arbiter.sv - directed self-checking bench for board_mem_arbiter
`timescale 1ns/1ps
module tb_board_mem_arbiter;

  logic       clk_in = 1'b0;
  logic       reset, enable;
  logic [2:0] vga_cell_x, vga_cell_y;
  logic [2:0] vga_status;
  logic       p_req, a_req, p_wr, a_wr;
  logic [2:0] p_cell_x, p_cell_y, a_cell_x, a_cell_y;
  logic [2:0] p_mask, a_mask;
  logic       p_ack, a_ack;
  logic [2:0] p_rdata, a_rdata;
  logic       clr_req, clr_busy, clr_done;
  logic [5:0] mem_addr;
  logic       mem_we;
  logic [2:0] mem_wdata;
  logic [2:0] mem_rdata = 3'd0;

  always #5 clk_in = ~clk_in;

  board_mem_arbiter #(.STATUS_W(3), .GRID_W(3)) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable),
    .vga_cell_x(vga_cell_x), .vga_cell_y(vga_cell_y), .vga_status(vga_status),
    .p_req(p_req), .a_req(a_req), .p_wr(p_wr), .a_wr(a_wr),
    .p_cell_x(p_cell_x), .p_cell_y(p_cell_y), .a_cell_x(a_cell_x), .a_cell_y(a_cell_y),
    .p_mask(p_mask), .a_mask(a_mask), .p_ack(p_ack), .a_ack(a_ack),
    .p_rdata(p_rdata), .a_rdata(a_rdata),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // board RAM: registered read, write on the same edge
  logic [2:0] ram [0:63];
  always @(posedge clk_in) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  // bus monitor, sampled mid-cycle
  int         wr_cnt = 0, wr_en_bad = 0, p_ack_cnt = 0, a_ack_cnt = 0;
  int         wr_hit [0:63];
  logic [5:0] last_wa = 6'd0;
  logic [2:0] last_wd = 3'd0;
  initial for (int i = 0; i < 64; i++) wr_hit[i] = 0;
  always @(negedge clk_in) begin
    if (mem_we === 1'b1) begin
      wr_cnt++;
      wr_hit[mem_addr]++;
      last_wa = mem_addr;
      last_wd = mem_wdata;
      if (enable) wr_en_bad++;
    end
    if (p_ack === 1'b1) p_ack_cnt++;
    if (a_ack === 1'b1) a_ack_cnt++;
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_ack(input bit ai, input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if ((ai ? a_ack : p_ack) === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic do_op(input bit ai, input bit wr, input logic [2:0] x, input logic [2:0] y,
                       input logic [2:0] mask, output int cyc, output logic [2:0] rd);
    if (ai) begin
      a_wr = wr; a_cell_x = x; a_cell_y = y; a_mask = mask; a_req = 1'b1;
    end else begin
      p_wr = wr; p_cell_x = x; p_cell_y = y; p_mask = mask; p_req = 1'b1;
    end
    wait_ack(ai, 40, cyc);
    rd = ai ? a_rdata : p_rdata;
    p_req = 1'b0;
    a_req = 1'b0;
    step();
  endtask

  task automatic both_round(output int p_at, output int a_at);
    p_at = -1;
    a_at = -1;
    p_wr = 1'b0; a_wr = 1'b0; p_req = 1'b1; a_req = 1'b1;
    for (int i = 1; i <= 20 && (p_at < 0 || a_at < 0); i++) begin
      step();
      if (p_ack === 1'b1 && p_at < 0) begin p_at = i; p_req = 1'b0; end
      if (a_ack === 1'b1 && a_at < 0) begin a_at = i; a_req = 1'b0; end
    end
    p_req = 1'b0;
    a_req = 1'b0;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         cyc, w0, pa0, en0, p_at, a_at, bad, done_cnt, gap, ack_early;
    int         base_hit [0:63];
    logic [2:0] rd;
    bit         done_seen, got_ack;

    reset = 1'b1; enable = 1'b0; vga_cell_x = 3'd0; vga_cell_y = 3'd0;
    p_req = 1'b0; a_req = 1'b0; p_wr = 1'b0; a_wr = 1'b0;
    p_cell_x = 3'd0; p_cell_y = 3'd0; a_cell_x = 3'd0; a_cell_y = 3'd0;
    p_mask = 3'd0; a_mask = 3'd0; clr_req = 1'b0;
    for (int i = 0; i < 64; i++) ram[i] = 3'd0;
    repeat (3) step();

    chk("rst_p_ack", 32'(p_ack), 0);
    chk("rst_a_ack", 32'(a_ack), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_clr_busy", 32'(clr_busy), 0);
    chk("rst_clr_done", 32'(clr_done), 0);
    chk("rst_vga_status", 32'(vga_status), 0);
    reset = 1'b0;

    // player read of cell (3,2) -> address 19
    ram[19] = 3'b101;
    w0 = wr_cnt;
    p_wr = 1'b0; p_cell_x = 3'd3; p_cell_y = 3'd2; p_req = 1'b1;
    step();
    chk("t1_rd_addr", 32'(mem_addr), 19);
    chk("t1_rd_we", 32'(mem_we), 0);
    step();
    chk("t1_ack", 32'(p_ack), 1);
    chk("t1_rdata", 32'(p_rdata), 32'b101);
    p_req = 1'b0;
    step();
    chk("t1_no_write", wr_cnt - w0, 0);

    // AI OR-set on cell (1,1) -> address 9, then player reads it back
    ram[9] = 3'b001;
    w0 = wr_cnt;
    do_op(1'b1, 1'b1, 3'd1, 3'd1, 3'b100, cyc, rd);
    chk("t2_ack_lat", cyc, 3);
    chk("t2_rdata", 32'(rd), 32'b001);
    chk("t2_writes", wr_cnt - w0, 1);
    chk("t2_waddr", 32'(last_wa), 9);
    chk("t2_wdata", 32'(last_wd), 32'b101);
    do_op(1'b0, 1'b0, 3'd1, 3'd1, 3'd0, cyc, rd);
    chk("t2_rb_lat", cyc, 2);
    chk("t2_rb_data", 32'(rd), 32'b101);

    // round-robin after reset: player first, then alternation
    reset = 1'b1;
    step();
    reset = 1'b0;
    p_cell_x = 3'd3; p_cell_y = 3'd2; a_cell_x = 3'd1; a_cell_y = 3'd1;
    both_round(p_at, a_at);
    chk("t3_r1_p_at", p_at, 2);
    chk("t3_r1_a_at", a_at, 5);
    do_op(1'b0, 1'b0, 3'd3, 3'd2, 3'd0, cyc, rd);
    chk("t3_solo_lat", cyc, 2);
    a_cell_x = 3'd1; a_cell_y = 3'd1;
    both_round(p_at, a_at);
    chk("t3_r3_a_at", a_at, 2);
    chk("t3_r3_p_at", p_at, 5);

    // player write aborted in WR by enable, then rerun in blanking
    ram[20] = 3'b010;
    vga_cell_x = 3'd4; vga_cell_y = 3'd2;
    w0 = wr_cnt; pa0 = p_ack_cnt;
    p_wr = 1'b1; p_cell_x = 3'd4; p_cell_y = 3'd2; p_mask = 3'b001; p_req = 1'b1;
    repeat (3) step();
    enable = 1'b1;
    #1;
    chk("t4_abort_we", 32'(mem_we), 0);
    chk("t4_abort_ack", 32'(p_ack), 0);
    chk("t4_vga_addr", 32'(mem_addr), 20);
    repeat (2) step();
    chk("t4_vga_status", 32'(vga_status), 32'b010);
    chk("t4_no_write_en", wr_cnt - w0, 0);
    chk("t4_no_ack_en", p_ack_cnt - pa0, 0);
    enable = 1'b0;
    wait_ack(1'b0, 20, cyc);
    chk("t4_rerun_lat", cyc, 3);
    chk("t4_rdata", 32'(p_rdata), 32'b010);
    p_req = 1'b0;
    step();
    chk("t4_one_write", wr_cnt - w0, 1);
    chk("t4_one_ack", p_ack_cnt - pa0, 1);
    chk("t4_ram", 32'(ram[20]), 32'b011);

    // full clear with enable toggling 10 on / 10 off, player read raised mid-clear
    for (int i = 0; i < 64; i++) begin
      ram[i] = 3'b111;
      base_hit[i] = wr_hit[i];
    end
    w0 = wr_cnt; en0 = wr_en_bad;
    done_cnt = 0; gap = 0; ack_early = 0; done_seen = 1'b0; got_ack = 1'b0;
    p_wr = 1'b0; p_cell_x = 3'd3; p_cell_y = 3'd2;
    clr_req = 1'b1;
    for (int k = 1; k < 400; k++) begin
      step();
      clr_req = 1'b0;
      if (clr_done === 1'b1) begin
        done_cnt++;
        done_seen = 1'b1;
      end
      if (!done_seen && clr_busy !== 1'b1) gap++;
      if (p_ack === 1'b1) begin
        got_ack = 1'b1;
        if (!done_seen) ack_early++;
        rd = p_rdata;
        break;
      end
      if (k == 30) p_req = 1'b1;
      enable = ((k / 10) % 2) == 1;
    end
    p_req = 1'b0;
    enable = 1'b0;
    step();
    bad = 0;
    for (int i = 0; i < 64; i++) if (wr_hit[i] - base_hit[i] != 1) bad++;
    chk("t5_writes", wr_cnt - w0, 64);
    chk("t5_addr_once", bad, 0);
    chk("t5_we_during_en", wr_en_bad - en0, 0);
    chk("t5_busy_gap", gap, 0);
    chk("t5_done_pulses", done_cnt, 1);
    chk("t5_p_acked", 32'(got_ack), 1);
    chk("t5_ack_before_done", ack_early, 0);
    chk("t5_rdata", 32'(rd), 0);
    bad = 0;
    for (int i = 0; i < 64; i++) if (ram[i] != 3'd0) bad++;
    chk("t5_ram_zero", bad, 0);

    // VGA reads cell (7,7); player request held off until blanking
    ram[63] = 3'b110;
    vga_cell_x = 3'd7; vga_cell_y = 3'd7;
    enable = 1'b1;
    #1;
    chk("t6_vga_addr", 32'(mem_addr), 63);
    step();
    chk("t6_vga_status", 32'(vga_status), 32'b110);
    pa0 = p_ack_cnt;
    p_wr = 1'b0; p_cell_x = 3'd7; p_cell_y = 3'd7; p_req = 1'b1;
    repeat (5) step();
    chk("t6_no_ack_en", p_ack_cnt - pa0, 0);
    enable = 1'b0;
    wait_ack(1'b0, 20, cyc);
    chk("t6_ack_lat", cyc, 2);
    chk("t6_rdata", 32'(p_rdata), 32'b110);
    p_req = 1'b0;
    step();

    // reset during WR: no write reaches the RAM
    ram[5] = 3'b001;
    w0 = wr_cnt;
    p_wr = 1'b1; p_cell_x = 3'd5; p_cell_y = 3'd0; p_mask = 3'b010; p_req = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    #1;
    chk("t7_rst_we", 32'(mem_we), 0);
    chk("t7_rst_ack", 32'(p_ack), 0);
    step();
    reset = 1'b0;
    p_req = 1'b0;
    step();
    chk("t7_no_write", wr_cnt - w0, 0);
    chk("t7_ram", 32'(ram[5]), 32'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
